// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the elastic pipeline stage register.
//   - Default payload/control widths (EX/MEM layout).
//   - EX/MEM payload field offsets: ALU result, store data, destination reg.
//   - Control bit indices used by downstream stages.
//   - pack_exmem(): assembles a default-layout payload from its fields.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Default payload: 32b ALU result, 32b store data, 5b rd
  localparam int RESULT_W   = 32;
  localparam int STDATA_W   = 32;
  localparam int RD_W       = 5;

  localparam int RD_LSB     = 0;
  localparam int STDATA_LSB = RD_LSB + RD_W;
  localparam int RESULT_LSB = STDATA_LSB + STDATA_W;

  localparam int DEF_DATA_W = RESULT_LSB + RESULT_W;  // 69
  localparam int DEF_CTRL_W = 5;

  // Control bit positions
  localparam int CTRL_REGWR = 0;
  localparam int CTRL_MEMWR = 1;
  localparam int CTRL_MEMRD = 2;
  localparam int CTRL_M2R   = 3;
  localparam int CTRL_BR    = 4;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [STDATA_W-1:0] stdata;
    logic [RD_W-1:0]     rd;
  } exmem_data_t;

  function automatic logic [DEF_DATA_W-1:0] pack_exmem(
    input logic [RESULT_W-1:0] result,
    input logic [STDATA_W-1:0] stdata,
    input logic [RD_W-1:0]     rd
  );
    exmem_data_t f;
    f.result = result;
    f.stdata = stdata;
    f.rd     = rd;
    return f;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   One valid/ready beat channel: valid, ready, data, ctrl.
//   Modports:
//     master : drives valid/data/ctrl, receives ready (producer side)
//     slave  : receives valid/data/ctrl, drives ready (consumer side)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);

endinterface

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//   Single-entry skid register with its full flag. Catches a beat accepted
//   while the main stage register is stalled.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (empties the buffer)
//     clear      flush: drop the held beat
//     push       capture in_data/in_ctrl, become full
//     pop        held beat moved into the main register, become empty
//     in_data/in_ctrl   beat to capture
//     full       buffer holds a beat
//     data/ctrl  held beat
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // push and pop never coincide: push needs a stalled main register, pop a free one.
  always_ff @(posedge clk) begin
    if (rst || clear)  full <= 1'b0;
    else if (push)     full <= 1'b1;
    else if (pop)      full <= 1'b0;
  end

  // NOTE: payload flops carry no reset; 'full' alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (push) begin
      data <= in_data;
      ctrl <= in_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline stage register with valid/ready handshake, stall by
//   backpressure and flush by bubble insertion. 1-cycle latency, 1 beat/cycle.
//   Build option: PIPE_STAGE_SKID_EN
//     defined   : main + skid register, in_ready registered (= !skid_full)
//     undefined : single register, in_ready = !out_valid | out_ready
//   Ports:
//     clk     clock
//     rst     synchronous active-high reset (priority over everything)
//     flush   drop all held beats and the beat offered this cycle
//     in_if   upstream channel (slave): valid, ready, data, ctrl
//     out_if  downstream channel (master): valid, ready, data, ctrl
//             ctrl is zero whenever valid is low
//     level   beats held after the last edge (0..2, 0..1 without skid)
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_stage_reg_if.slave         in_if,
  pipe_stage_reg_if.master        out_if,
  output logic [1:0]              level
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;

  logic              main_free;
  logic              accept;

  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Main register can take a new beat this edge when it is empty or retiring.
  assign main_free = !main_valid || out_if.ready;
  // A beat offered during flush is discarded, so it never counts as accepted.
  assign accept    = in_if.valid && in_if.ready && !flush;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_push;
  logic skid_pop;

  // Ready comes straight from a flop: no out_ready -> in_ready path.
  assign in_if.ready = !skid_full;
  assign skid_push   = accept && !main_free;
  assign skid_pop    = main_free && skid_full && !flush;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .push    (skid_push),
    .pop     (skid_pop),
    .in_data (in_if.data),
    .in_ctrl (in_if.ctrl),
    .full    (skid_full),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );
`else
  assign in_if.ready = main_free;
  assign skid_full   = 1'b0;
  assign skid_data   = '0;
  assign skid_ctrl   = '0;
`endif

  // Skid beat is older than anything on the input, so it loads first; while
  // the skid is full in_ready is low, so no input beat competes with it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_full) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_if.data;
        main_ctrl  <= in_if.ctrl;
      end else begin
        // Bubble: clear control so no side effects leak; data is don't-care.
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end
  end

  assign out_if.valid = main_valid;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = main_ctrl;   // already zero whenever main_valid is low

  assign level = {1'b0, main_valid} + {1'b0, skid_full};

endmodule

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Table-driven directed vectors (streaming, reset mid-stall, bubbles,
//   stall/skid, flush) followed by randomized traffic compared against a
//   queue-based occupancy model. Works for both PIPE_STAGE_SKID_EN builds.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int CW = DEF_CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [DW-1:0] DA = DW'(32'h0AA);
  localparam logic [DW-1:0] DB = DW'(32'h0BB);
  localparam logic [DW-1:0] DC = DW'(32'h0CC);
  localparam logic [DW-1:0] DZ = '0;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] level;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) in_if ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) out_if ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_if),
    .out_if (out_if),
    .level  (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
    rst          = r;
    flush        = f;
    in_if.valid  = iv;
    in_if.data   = d;
    in_if.ctrl   = c;
    out_if.ready = ordy;
  endtask

  // One row = inputs held for one cycle, and outputs expected while they are held.
  typedef struct {
    logic          r, f, iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          e_valid, e_ready;
    logic [DW-1:0] e_data;
    logic          e_chk_data;
    logic [CW-1:0] e_ctrl;
    logic [1:0]    e_level;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, f, iv, input logic [DW-1:0] d,
                              input logic [CW-1:0] c, input logic ordy,
                              input logic ev, er, input logic [DW-1:0] ed,
                              input logic chk, input logic [CW-1:0] ec, input logic [1:0] el);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.e_valid = ev; v.e_ready = er; v.e_data = ed; v.e_chk_data = chk;
    v.e_ctrl = ec; v.e_level = el;
    return v;
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t model_q[$];

  initial begin
    drive(1'b1, 1'b0, 1'b0, DZ, '0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // ---- Streaming: beat i visible on the cycle after it is offered ----
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 1, DW'(32'h100 + i), 5'b00001, 1,
                        i > 0, 1, DW'(32'h100 + i - 1), i > 0,
                        (i > 0) ? 5'b00001 : 5'b00000, (i > 0) ? 2'd1 : 2'd0));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 1, 1, DW'(32'h107), 1, 5'b00001, 2'd1));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));

    // ---- Reset mid-stall; a beat offered during reset is also dropped ----
    vecs.push_back(mk(0, 0, 1, DW'(32'h55), 5'b10101, 0, 0, 1, DZ, 0, 5'b00000, 2'd0));
    vecs.push_back(mk(1, 0, 1, DW'(32'h66), 5'b11111, 0, 1, SKID, DW'(32'h55), 1, 5'b10101, 2'd1));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 0, 0, 1, DZ, 1, 5'b00000, 2'd0));

    // ---- Bubbles with all control bits driven high on the input ----
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, DW'(32'h77), 5'b11111, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));

    // ---- Stall: A then B while out_ready=0, then release ----
    vecs.push_back(mk(0, 0, 1, DA, 5'b00010, 0, 0, 1, DZ, 0, 5'b00000, 2'd0));
`ifdef PIPE_STAGE_SKID_EN
    vecs.push_back(mk(0, 0, 1, DB, 5'b00011, 0, 1, 1, DA, 1, 5'b00010, 2'd1));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 0, 1, 0, DA, 1, 5'b00010, 2'd2));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 1, 0, DA, 1, 5'b00010, 2'd2));
`else
    vecs.push_back(mk(0, 0, 1, DB, 5'b00011, 0, 1, 0, DA, 1, 5'b00010, 2'd1));
    vecs.push_back(mk(0, 0, 1, DB, 5'b00011, 0, 1, 0, DA, 1, 5'b00010, 2'd1));
    vecs.push_back(mk(0, 0, 1, DB, 5'b00011, 1, 1, 1, DA, 1, 5'b00010, 2'd1));
`endif
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 1, 1, DB, 1, 5'b00011, 2'd1));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));

    // ---- Flush with the stage full, beat C offered in the flush cycle ----
    vecs.push_back(mk(0, 0, 1, DA, 5'b00010, 0, 0, 1, DZ, 0, 5'b00000, 2'd0));
`ifdef PIPE_STAGE_SKID_EN
    vecs.push_back(mk(0, 0, 1, DB, 5'b00011, 0, 1, 1, DA, 1, 5'b00010, 2'd1));
    vecs.push_back(mk(0, 1, 1, DC, 5'b00100, 0, 1, 0, DA, 1, 5'b00010, 2'd2));
`else
    vecs.push_back(mk(0, 1, 1, DC, 5'b00100, 0, 1, 0, DA, 1, 5'b00010, 2'd1));
`endif
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));

    // ---- Flush while C would otherwise be accepted ----
    vecs.push_back(mk(0, 0, 1, DA, 5'b00010, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));
    vecs.push_back(mk(0, 1, 1, DC, 5'b00100, 1, 1, 1, DA, 1, 5'b00010, 2'd1));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));
    vecs.push_back(mk(0, 0, 0, DZ, '0, 1, 0, 1, DZ, 0, 5'b00000, 2'd0));

    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].f, vecs[k].iv, vecs[k].d, vecs[k].c, vecs[k].ordy);
      @(negedge clk);
      check($sformatf("vec%0d.valid", k), 128'(out_if.valid), 128'(vecs[k].e_valid));
      check($sformatf("vec%0d.ready", k), 128'(in_if.ready),  128'(vecs[k].e_ready));
      check($sformatf("vec%0d.ctrl",  k), 128'(out_if.ctrl),  128'(vecs[k].e_ctrl));
      check($sformatf("vec%0d.level", k), 128'(level),        128'(vecs[k].e_level));
      if (vecs[k].e_chk_data)
        check($sformatf("vec%0d.data", k), 128'(out_if.data), 128'(vecs[k].e_data));
      @(posedge clk); #1;
    end

    // ---- Randomized traffic against an occupancy-queue model ----
    drive(1'b1, 1'b0, 1'b0, DZ, '0, 1'b1);
    @(posedge clk); #1;
    model_q.delete();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic          r, f, iv, ordy, exp_ready, retire, acc;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      beat_t         b;

      r    = ($urandom_range(0, 149) == 0);
      f    = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      d    = pack_exmem($urandom, $urandom, 5'($urandom));
      c    = CW'($urandom);
      // Second half: out_ready toggles every cycle.
      ordy = (cyc >= 2000) ? 1'(cyc & 1) : ($urandom_range(0, 3) != 0);
      drive(r, f, iv, d, c, ordy);

      // Ready rule: skid build takes a beat while fewer than two are held;
      // single register takes one when empty or when its beat leaves.
      exp_ready = SKID ? (model_q.size() < 2) : (model_q.size() == 0 || ordy);

      @(negedge clk);
      check($sformatf("rnd%0d.valid", cyc), 128'(out_if.valid), 128'(model_q.size() > 0));
      check($sformatf("rnd%0d.level", cyc), 128'(level),        128'(model_q.size()));
      check($sformatf("rnd%0d.ready", cyc), 128'(in_if.ready),  128'(exp_ready));
      check($sformatf("rnd%0d.ctrl",  cyc), 128'(out_if.ctrl),
            128'((model_q.size() > 0) ? model_q[0].c : '0));
      if (model_q.size() > 0)
        check($sformatf("rnd%0d.data", cyc), 128'(out_if.data), 128'(model_q[0].d));

      if (r || f) begin
        model_q.delete();
      end else begin
        retire = (model_q.size() > 0) && ordy;
        acc    = iv && exp_ready;
        if (retire) void'(model_q.pop_front());
        if (acc) begin
          b.d = d;
          b.c = c;
          model_q.push_back(b);
        end
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
